// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
// Bundles the operation request, MTHI/MTLO write and HI/LO result signals of
// the iterative multiply/divide unit.
//   start   : launch an operation (sampled only while the unit is idle)
//   op      : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b    : operands rs / rt
//   hi_we   : MTHI write enable
//   lo_we   : MTLO write enable
//   wd      : MTHI/MTLO write data
//   hi, lo  : architectural HI/LO registers
//   busy    : operation in progress
//   done    : one-cycle pulse when HI/LO receive a result
// The master modport is the requester (control/datapath or a testbench);
// the slave modport is the unit itself.
// -----------------------------------------------------------------------------
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b, hi_we, lo_we, wd,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wd,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division; both run on the
// unsigned magnitudes for WIDTH iterations and then apply sign correction in
// a single FIX cycle. Latency from the start edge to HI/LO update: WIDTH+1.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous reset, active low
//   bus    : muldiv_unit_if slave modport (request, MT writes, results)
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic           clk,
    input  logic           reset,
    muldiv_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // acc: running product high half (multiply) or partial remainder (divide)
    logic [WIDTH-1:0]   acc_q, acc_d;
    // low: multiplier shifting out / product low half, or dividend shifting
    // out / quotient shifting in
    logic [WIDTH-1:0]   low_q, low_d;
    // opnd: multiplicand or divisor magnitude
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               res_neg_q, res_neg_d;   // negate product / quotient
    logic               rem_neg_q, rem_neg_d;   // negate remainder
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Operand decode for launch
    logic               op_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign op_signed = ~bus.op[0];
    assign a_neg     = op_signed & bus.a[WIDTH-1];
    assign b_neg     = op_signed & bus.b[WIDTH-1];
    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned
    // magnitude, so the most negative value needs no special case.
    assign a_mag     = a_neg ? (~bus.a + 1'b1) : bus.a;
    assign b_mag     = b_neg ? (~bus.b + 1'b1) : bus.b;

    // One shift-add step: add multiplicand when the multiplier LSB is set,
    // then shift the {acc, low} pair right by one.
    logic [WIDTH:0]     mul_sum;
    assign mul_sum = {1'b0, acc_q} + {1'b0, (low_q[0] ? opnd_q : '0)};

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder and try subtracting the divisor. The remainder is
    // always below the divisor, so the shifted value fits in WIDTH+1 bits
    // and bit WIDTH of the difference is the borrow.
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_borrow;
    assign div_shift  = {acc_q, low_q[WIDTH-1]};
    assign div_diff   = div_shift - {1'b0, opnd_q};
    assign div_borrow = div_diff[WIDTH];

    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fix;
    assign prod_mag = {acc_q, low_q};
    assign prod_fix = res_neg_q ? (~prod_mag + 1'b1) : prod_mag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            low_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            low_q     <= low_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        low_d     = low_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.hi_we) hi_d = bus.wd;
                if (bus.lo_we) lo_d = bus.wd;
                if (bus.start) begin
                    is_div_d  = bus.op[1];
                    low_d     = a_mag;
                    opnd_d    = b_mag;
                    acc_d     = '0;
                    cnt_d     = '0;
                    // A zero divisor must leave the all-ones quotient
                    // unnegated; the remainder (= dividend magnitude) with the
                    // dividend's sign then reproduces a exactly.
                    res_neg_d = (a_neg ^ b_neg) & ~(bus.op[1] & (bus.b == '0));
                    rem_neg_d = a_neg;
                    busy_d    = 1'b1;
                    state_d   = ST_RUN;
                end
            end

            ST_RUN: begin
                if (is_div_q) begin
                    if (div_borrow) begin
                        acc_d = div_shift[WIDTH-1:0];
                        low_d = {low_q[WIDTH-2:0], 1'b0};
                    end else begin
                        acc_d = div_diff[WIDTH-1:0];
                        low_d = {low_q[WIDTH-2:0], 1'b1};
                    end
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    low_d = {mul_sum[0], low_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                if (is_div_q) begin
                    lo_d = res_neg_q ? (~low_q + 1'b1) : low_q;
                    hi_d = rem_neg_q ? (~acc_q + 1'b1) : acc_q;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    localparam int W = 32;

    logic clk;
    logic reset;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        string        name;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no result pending");
            end else begin
                e = exp_q.pop_front();
                chk({e.name, ".hi"}, bus.hi, e.hi);
                chk({e.name, ".lo"}, bus.lo, e.lo);
            end
        end
    end

    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
    endtask

    // Launch an operation, check busy lasts 33 cycles, and let the monitor
    // check the result.
    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int cycles;
        exp_t e;
        e.hi = ehi; e.lo = elo; e.name = name;
        exp_q.push_back(e);
        @(negedge clk);
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = '1; bus.b = '1; bus.op = ~op;   // latched copies only
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        chk({name, ".busy_cycles"}, W'(cycles), 32'd33);
        @(negedge clk);
    endtask

    initial begin
        int dc;
        idle_inputs();
        bus.op = 2'b00; bus.a = '0; bus.b = '0; bus.wd = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.hi", bus.hi, 32'h0);
        chk("reset.lo", bus.lo, 32'h0);
        chk("reset.busy", W'(bus.busy), 32'h0);
        chk("reset.done", W'(bus.done), 32'h0);
        reset = 1'b1;
        @(negedge clk);

        dc = done_cnt;
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        repeat (3) @(negedge clk);
        chk("multu_max.done_pulses", W'(done_cnt - dc), 32'd1);

        run_op("mult_neg7x6",  2'b00, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6);
        run_op("mult_minsq",   2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        run_op("div_m17_5",    2'b10, 32'hFFFF_FFEF, 32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_op("div_7_m2",     2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        run_op("divu_100_7",   2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("divu_by0",     2'b11, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF);
        run_op("div_m5_by0",   2'b10, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("div_min_m1",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        // Idle MTHI/MTLO together
        @(negedge clk);
        bus.wd = 32'hA5A5_A5A5; bus.hi_we = 1'b1; bus.lo_we = 1'b1;
        @(negedge clk);
        idle_inputs();
        chk("mt_both.hi", bus.hi, 32'hA5A5_A5A5);
        chk("mt_both.lo", bus.lo, 32'hA5A5_A5A5);

        // MULTU 3*4 with a start+MTHI attempt mid-run
        begin
            exp_t e;
            e.hi = 32'h0; e.lo = 32'd12; e.name = "multu_3x4_ignore";
            exp_q.push_back(e);
        end
        bus.op = 2'b01; bus.a = 32'd3; bus.b = 32'd4; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.op = 2'b10; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
        bus.wd = 32'hDEAD_BEEF; bus.hi_we = 1'b1;
        @(negedge clk);
        idle_inputs();
        chk("midrun_mthi_ignored.hi", bus.hi, 32'hA5A5_A5A5);
        chk("midrun.busy", W'(bus.busy), 32'd1);
        begin
            int t = 0;
            while (bus.busy === 1'b1 && t < 100) begin t++; @(negedge clk); end
            checks++;
            if (t >= 100) begin errors++; $display("FAIL midrun_timeout: busy stuck at 1 expected 0"); end
        end
        repeat (3) @(negedge clk);
        chk("midrun.no_second_op", W'(bus.busy), 32'd0);

        // MTHI in the same cycle as start: write at E0, result overwrites later
        begin
            exp_t e;
            e.hi = 32'h0; e.lo = 32'd6; e.name = "start_with_mthi";
            exp_q.push_back(e);
        end
        bus.op = 2'b01; bus.a = 32'd2; bus.b = 32'd3; bus.start = 1'b1;
        bus.wd = 32'h55; bus.hi_we = 1'b1;
        @(negedge clk);
        idle_inputs();
        chk("start_with_mthi.hi_at_e0", bus.hi, 32'h55);
        repeat (40) @(negedge clk);

        // Reset at cycle 10 of a DIV: abort, no result
        dc = done_cnt;
        bus.op = 2'b10; bus.a = 32'd1000; bus.b = 32'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort.hi", bus.hi, 32'h0);
        chk("abort.lo", bus.lo, 32'h0);
        chk("abort.busy", W'(bus.busy), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort.no_done", W'(done_cnt - dc), 32'd0);
        chk("abort.lo_after", bus.lo, 32'h0);

        chk("scoreboard_drained", W'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
- Sits directly downstream of registerfile32: operands a/b come from rd1/rd2. HI/LO feed the MFHI/MFLO writeback path.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles. Asserts busy so the control unit can stall on MFHI/MFLO.
- Also supports MTHI/MTLO direct writes.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous reset, active-low (0 = reset)
- start  input  1  launch operation; sampled only when idle
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  WIDTH  operand rs (multiplicand / dividend), from rd1
- b  input  WIDTH  operand rt (multiplier / divisor), from rd2
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wd  input  WIDTH  MTHI/MTLO write data
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO receive a result

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal operand registers=0.
- Reset mid-operation aborts the operation. No partial result is ever written.
- States are IDLE, RUN, FIX.
- IDLE, start=1 at edge E0:
  - Latch the magnitudes of a and b (absolute value for signed ops; raw value for unsigned ops).
  - Latch the result sign flags.
  - counter=0, state=RUN, busy=1 after E0.
- IDLE, start=0: hold.
- RUN: one iteration per edge, counter increments. After the WIDTH-th iteration edge (E0+32 by default), state=FIX.
  - Multiply: shift-add, 64-bit unsigned product of the magnitudes.
  - Divide: restoring, one quotient bit per cycle, unsigned quotient and remainder of the magnitudes.
- FIX, one edge (E0+33):
  - Apply sign correction.
  - Write hi/lo.
  - done=1 for exactly this cycle, busy=0, state=IDLE.
  - Total latency: start edge to result visible is 33 edges. done is high during the cycle following E0+33.
- Result mapping:
  - Multiply: {hi,lo} = full 64-bit product. Signed product is two's complement when the operand signs differ.
  - Divide: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero. Remainder takes the sign of the dividend.
- Divide boundary cases:
  - Divide by zero (b=0), signed or unsigned: hi=a, lo=all ones. Full latency, no exception.
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Signed magnitude of 0x80000000 is handled as unsigned 0x80000000 with no overflow.
- start while busy (RUN/FIX): ignored, no queuing.
- hi_we/lo_we:
  - Honoured only in IDLE. hi/lo<=wd at the edge. Both may be set in the same cycle.
  - Ignored while busy; the pending result wins.
- IDLE with start and hi_we/lo_we in the same cycle: the MT write takes effect at E0 and the operation is launched. The result overwrites both hi and lo at completion.
- Operand inputs a/b/op may change freely after E0; only the latched copies are used.
- busy and done are registered outputs with no combinational path from inputs.

Test Plan:
- Reset then MULTU a=0xFFFFFFFF, b=0xFFFFFFFF:
  - busy=1 for 33 cycles.
  - done pulses once.
  - hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=-7 (0xFFFFFFF9), b=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6 (-42).
- DIV a=-17, b=5 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFE (-2).
- DIVU a=100, b=7 -> lo=14, hi=2.
- Divide boundary cases:
  - DIVU a=0x1234, b=0 -> hi=0x1234, lo=0xFFFFFFFF.
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Control corner cases:
  - Idle hi_we=1, lo_we=1, wd=0xA5A5A5A5 -> hi=lo=0xA5A5A5A5.
  - Launch MULTU 3*4, then pulse start with a different op and hi_we mid-run -> both ignored; result hi=0, lo=12.
  - Assert reset=0 at cycle 10 of a DIV -> hi=lo=0, busy=0 immediately, no done pulse.
